// File: rtl/tx_merge_arbiter_pkg.sv
// Shared types and default widths for the transmit merge arbiter.
// No logic; state encoding is 4 bits wide so it lines up with the existing state machine.
// Source-select enum is used for both the round-robin pointer and the pipeline tag.
package tx_merge_arbiter_pkg;

    localparam int DATA_WIDTH   = 6;
    localparam int CREDIT_WIDTH = 4;

    typedef enum logic [3:0] {
        ST_RESET  = 4'd0,
        ST_INIT   = 4'd1,
        ST_IDLE   = 4'd2,
        ST_ACTIVE = 4'd3
    } state_e;

    typedef enum logic {
        SEL_SRC0 = 1'b0,
        SEL_SRC1 = 1'b1
    } src_sel_e;

endpackage

// File: rtl/tx_merge_arbiter_if.sv
// Stream bundle between the two source FIFOs, the arbiter and the downstream main FIFO.
// Latency: none (wires only).
// Backpressure: expressed by the arbiter's credit counter, returned via credit_return.
// Ports: src0/src1 read data + empty, pop strobes, merged write data/strobe, credit return.
interface tx_merge_arbiter_if #(
    parameter int DATA_WIDTH = tx_merge_arbiter_pkg::DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] src0_data;
    logic                  src0_empty;
    logic [DATA_WIDTH-1:0] src1_data;
    logic                  src1_empty;
    logic                  pop_src0;
    logic                  pop_src1;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  wr_enable;
    logic                  credit_return;

    // master: the arbiter; slave: source FIFOs and downstream FIFO side.
    modport master (
        input  src0_data, src0_empty, src1_data, src1_empty, credit_return,
        output pop_src0, pop_src1, data_out, wr_enable
    );

    modport slave (
        output src0_data, src0_empty, src1_data, src1_empty, credit_return,
        input  pop_src0, pop_src1, data_out, wr_enable
    );
endinterface

// File: rtl/tx_merge_arbiter_credit_counter.sv
// Downstream credit counter: load, +1 on return, -1 on pop, saturates at the loaded max.
// Latency: count and error update one cycle after load/inc/dec.
// Backpressure: count of zero is what stalls the arbiter; return at max sets a sticky error.
// Ports: clk/reset, load + load_val, inc, dec; outputs credits and error.
module tx_merge_arbiter_credit_counter #(
    parameter int CREDIT_WIDTH = tx_merge_arbiter_pkg::CREDIT_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [CREDIT_WIDTH-1:0] load_val,
    input  logic                    inc,
    input  logic                    dec,
    output logic [CREDIT_WIDTH-1:0] credits,
    output logic                    error
);
    logic [CREDIT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CREDIT_WIDTH-1:0] max_q, max_d;
    logic                    err_q, err_d;

    always_comb begin
        cnt_d = cnt_q;
        max_d = max_q;
        err_d = err_q;
        if (load) begin
            cnt_d = load_val;
            max_d = load_val;
            err_d = 1'b0;
        end else begin
            unique case ({inc, dec})
                2'b10: begin
                    // A return with nothing outstanding means the downstream side lost track.
                    if (cnt_q == max_q) err_d = 1'b1;
                    else                cnt_d = cnt_q + 1'b1;
                end
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            max_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            max_q <= max_d;
            err_q <= err_d;
        end
    end

    assign credits = cnt_q;
    assign error   = err_q;
endmodule

// File: rtl/tx_merge_arbiter.sv
// Merges two source FIFO streams round-robin into one write stream for the main FIFO.
// Latency: 2 cycles from pop to wr_enable; back-to-back pops give back-to-back writes.
// Backpressure: pops only while credits > 0; credits come back via credit_return.
// Ports: clk/reset, init + umbral_credits, stream bus (master modport), status outputs.
module tx_merge_arbiter
    import tx_merge_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = tx_merge_arbiter_pkg::DATA_WIDTH,
    parameter int CREDIT_WIDTH = tx_merge_arbiter_pkg::CREDIT_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    init,
    input  logic [CREDIT_WIDTH-1:0] umbral_credits,
    tx_merge_arbiter_if.master      bus,
    output logic [CREDIT_WIDTH-1:0] credits_out,
    output logic                    error_out,
    output logic                    idle_out,
    output logic                    active_out
);
    state_e                state_q, state_d;
    src_sel_e              rr_q, rr_d;
    src_sel_e              stg1_sel_q, stg1_sel_d;
    logic                  stg1_vld_q, stg1_vld_d;
    logic                  wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  idle_q, idle_d;
    logic                  active_q, active_d;

    logic                    pop0, pop1, pop_ok, run_st;
    logic                    src0_avail, src1_avail;
    logic [CREDIT_WIDTH-1:0] credits;
    logic                    credit_err;

    assign src0_avail = !bus.src0_empty;
    assign src1_avail = !bus.src1_empty;
    assign run_st     = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);

    // Pop issue looks only at registered state/credits and the live empty flags.
    always_comb begin
        pop0   = 1'b0;
        pop1   = 1'b0;
        rr_d   = rr_q;
        pop_ok = !reset && !init && run_st && (credits != '0);
        if (pop_ok) begin
            if (src0_avail && src1_avail) begin
                if (rr_q == SEL_SRC0) pop0 = 1'b1;
                else                  pop1 = 1'b1;
                rr_d = (rr_q == SEL_SRC0) ? SEL_SRC1 : SEL_SRC0;
            end else if (src0_avail) begin
                pop0 = 1'b1;
                rr_d = SEL_SRC1;
            end else if (src1_avail) begin
                pop1 = 1'b1;
                rr_d = SEL_SRC0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (init) begin
            state_d = ST_INIT;
        end else begin
            unique case (state_q)
                ST_RESET:  state_d = ST_RESET;
                ST_INIT:   state_d = ST_IDLE;
                ST_IDLE:   if ((src0_avail || src1_avail) && (credits != '0)) state_d = ST_ACTIVE;
                ST_ACTIVE: if (!src0_avail && !src1_avail && !stg1_vld_q && !wr_en_q) state_d = ST_IDLE;
                default:   state_d = ST_RESET;
            endcase
        end

        // Stage 1 remembers which source was popped; stage 2 captures its data one cycle later.
        stg1_vld_d = pop0 || pop1;
        stg1_sel_d = pop1 ? SEL_SRC1 : SEL_SRC0;
        wr_en_d    = stg1_vld_q;
        data_d     = data_q;
        if (stg1_vld_q) data_d = (stg1_sel_q == SEL_SRC1) ? bus.src1_data : bus.src0_data;

        // Status flags are computed from next-cycle values so they line up with state_q.
        idle_d   = (state_d == ST_IDLE) && !stg1_vld_d && !wr_en_d;
        active_d = (state_d == ST_ACTIVE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RESET;
            rr_q       <= SEL_SRC0;
            stg1_sel_q <= SEL_SRC0;
            stg1_vld_q <= 1'b0;
            wr_en_q    <= 1'b0;
            data_q     <= '0;
            idle_q     <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            stg1_sel_q <= stg1_sel_d;
            stg1_vld_q <= stg1_vld_d;
            wr_en_q    <= wr_en_d;
            data_q     <= data_d;
            idle_q     <= idle_d;
            active_q   <= active_d;
        end
    end

    // Returns are only meaningful once credits have been loaded and the block is running.
    tx_merge_arbiter_credit_counter #(
        .CREDIT_WIDTH (CREDIT_WIDTH)
    ) u_credit_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (state_q == ST_INIT),
        .load_val (umbral_credits),
        .inc      (bus.credit_return && run_st),
        .dec      (pop0 || pop1),
        .credits  (credits),
        .error    (credit_err)
    );

    assign bus.pop_src0  = pop0;
    assign bus.pop_src1  = pop1;
    assign bus.data_out  = data_q;
    assign bus.wr_enable = wr_en_q;
    assign credits_out   = credits;
    assign error_out     = credit_err;
    assign idle_out      = idle_q;
    assign active_out    = active_q;
endmodule

// File: tb/tb_tx_merge_arbiter.sv
// Directed bench for tx_merge_arbiter: source FIFO models, per-cycle pop/write log, fixed expectations.
// Latency: n/a.
// Backpressure: n/a.
module tb_tx_merge_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic       init;
    logic [3:0] umbral_credits;
    logic [3:0] credits_out;
    logic       error_out;
    logic       idle_out;
    logic       active_out;

    tx_merge_arbiter_if #(.DATA_WIDTH(6)) bus ();

    tx_merge_arbiter #(.DATA_WIDTH(6), .CREDIT_WIDTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .init           (init),
        .umbral_credits (umbral_credits),
        .bus            (bus),
        .credits_out    (credits_out),
        .error_out      (error_out),
        .idle_out       (idle_out),
        .active_out     (active_out)
    );

    always #5 clk = ~clk;

    logic [5:0] q0[$];
    logic [5:0] q1[$];
    int         pop_log[$];  // per cycle: {pop_src1, pop_src0}
    int         wr_log[$];   // per cycle: written data, or -1 when no write
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: log pops/writes at the negedge, then update source FIFO models just after posedge.
    task automatic tick();
        logic p0, p1;
        @(negedge clk);
        p0 = bus.pop_src0;
        p1 = bus.pop_src1;
        pop_log.push_back({30'd0, p1, p0});
        wr_log.push_back(bus.wr_enable ? int'(bus.data_out) : -1);
        @(posedge clk);
        #1;
        if (p0 && q0.size() > 0) bus.src0_data = q0.pop_front();
        if (p1 && q1.size() > 0) bus.src1_data = q1.pop_front();
        bus.src0_empty    = (q0.size() == 0);
        bus.src1_empty    = (q1.size() == 0);
        bus.credit_return = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push0(input logic [5:0] v);
        q0.push_back(v);
        bus.src0_empty = 1'b0;
    endtask

    task automatic push1(input logic [5:0] v);
        q1.push_back(v);
        bus.src1_empty = 1'b0;
    endtask

    task automatic clear_logs();
        pop_log.delete();
        wr_log.delete();
    endtask

    function automatic int count_writes();
        int n = 0;
        foreach (wr_log[i]) if (wr_log[i] != -1) n++;
        return n;
    endfunction

    function automatic int count_pops();
        int n = 0;
        foreach (pop_log[i]) if (pop_log[i] != 0) n++;
        return n;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        init  = 1'b0;
        q0.delete();
        q1.delete();
        bus.src0_empty = 1'b1;
        bus.src1_empty = 1'b1;
        ticks(3);
        reset = 1'b0;
    endtask

    task automatic do_init(input logic [3:0] u);
        umbral_credits = u;
        init = 1'b1;
        ticks(2);
        init = 1'b0;
        ticks(2);
    endtask

    initial begin
        int exp_pop[7];
        int exp_wr[6];

        reset = 1'b1;
        init = 1'b0;
        umbral_credits = 4'd0;
        bus.src0_data = '0;
        bus.src1_data = '0;
        bus.src0_empty = 1'b1;
        bus.src1_empty = 1'b1;
        bus.credit_return = 1'b0;

        // Reset state, with a non-empty source to show no pop escapes during reset.
        push0(6'h01);
        ticks(3);
        check_eq("rst_credits", 32'(credits_out), 32'd0);
        check_eq("rst_error",   32'(error_out),   32'd0);
        check_eq("rst_idle",    32'(idle_out),    32'd0);
        check_eq("rst_active",  32'(active_out),  32'd0);
        check_eq("rst_wr",      32'(bus.wr_enable), 32'd0);
        check_eq("rst_data",    32'(bus.data_out),  32'd0);
        check_eq("rst_pop0",    32'(bus.pop_src0),  32'd0);
        do_reset();

        // 1: init with 4 credits, sources empty.
        do_init(4'd4);
        check_eq("t1_credits", 32'(credits_out), 32'd4);
        check_eq("t1_idle",    32'(idle_out),    32'd1);
        check_eq("t1_active",  32'(active_out),  32'd0);
        check_eq("t1_pops",    32'({bus.pop_src1, bus.pop_src0}), 32'd0);
        check_eq("t1_wr",      32'(bus.wr_enable), 32'd0);

        // 2: src0 only, three words.
        clear_logs();
        push0(6'h0A); push0(6'h0B); push0(6'h0C);
        ticks(2);
        check_eq("t2_active_mid", 32'(active_out), 32'd1);
        ticks(6);
        exp_pop = '{1, 1, 1, 0, 0, 0, 0};
        for (int i = 0; i < 4; i++) check_eq($sformatf("t2_pop%0d", i), 32'(pop_log[i]), 32'(exp_pop[i]));
        check_eq("t2_wr1", 32'(wr_log[1]), 32'hFFFF_FFFF);
        check_eq("t2_wr2", 32'(wr_log[2]), 32'h0A);
        check_eq("t2_wr3", 32'(wr_log[3]), 32'h0B);
        check_eq("t2_wr4", 32'(wr_log[4]), 32'h0C);
        check_eq("t2_wr5", 32'(wr_log[5]), 32'hFFFF_FFFF);
        check_eq("t2_credits", 32'(credits_out), 32'd1);
        check_eq("t2_idle",    32'(idle_out),    32'd1);
        check_eq("t2_active",  32'(active_out),  32'd0);

        // 3: both sources, round robin starting at src0 after reset.
        do_reset();
        do_init(4'd8);
        clear_logs();
        push0(6'h11); push0(6'h12); push0(6'h13);
        push1(6'h21); push1(6'h22); push1(6'h23);
        ticks(10);
        exp_pop = '{1, 2, 1, 2, 1, 2, 0};
        exp_wr  = '{'h11, 'h21, 'h12, 'h22, 'h13, 'h23};
        for (int i = 0; i < 7; i++) check_eq($sformatf("t3_pop%0d", i), 32'(pop_log[i]), 32'(exp_pop[i]));
        for (int i = 0; i < 6; i++) check_eq($sformatf("t3_wr%0d", i + 2), 32'(wr_log[i + 2]), 32'(exp_wr[i]));
        check_eq("t3_credits", 32'(credits_out), 32'd2);

        // 4: two credits, five words -> stall, then one return yields one pop.
        do_init(4'd2);
        clear_logs();
        push0(6'h31); push0(6'h32); push0(6'h33); push0(6'h34); push0(6'h35);
        ticks(6);
        check_eq("t4_pops",    32'(count_pops()), 32'd2);
        check_eq("t4_wr2",     32'(wr_log[2]), 32'h31);
        check_eq("t4_wr3",     32'(wr_log[3]), 32'h32);
        check_eq("t4_credits", 32'(credits_out), 32'd0);
        check_eq("t4_active",  32'(active_out),  32'd1);
        clear_logs();
        bus.credit_return = 1'b1;
        ticks(5);
        check_eq("t4r_pop0", 32'(pop_log[0]), 32'd0);
        check_eq("t4r_pop1", 32'(pop_log[1]), 32'd1);
        check_eq("t4r_pop2", 32'(pop_log[2]), 32'd0);
        check_eq("t4r_wr3",  32'(wr_log[3]),  32'h33);
        check_eq("t4r_credits", 32'(credits_out), 32'd0);

        // 5: pop and return in the same cycle, then overflow at max.
        clear_logs();
        bus.credit_return = 1'b1;
        tick();
        bus.credit_return = 1'b1;
        tick();
        check_eq("t5_same_pop",     32'(pop_log[1]), 32'd1);
        check_eq("t5_same_credits", 32'(credits_out), 32'd1);
        ticks(5);
        check_eq("t5_drained", 32'(credits_out), 32'd0);
        bus.credit_return = 1'b1; tick();
        bus.credit_return = 1'b1; tick();
        check_eq("t5_at_max", 32'(credits_out), 32'd2);
        check_eq("t5_no_err", 32'(error_out),   32'd0);
        bus.credit_return = 1'b1; tick();
        check_eq("t5_ovf_credits", 32'(credits_out), 32'd2);
        check_eq("t5_ovf_err",     32'(error_out),   32'd1);
        clear_logs();
        push0(6'h3A); push0(6'h3B);
        ticks(6);
        check_eq("t5_traffic_wr", 32'(count_writes()), 32'd2);
        check_eq("t5_sticky_err", 32'(error_out),      32'd1);
        do_init(4'd4);
        check_eq("t5_init_err",     32'(error_out),   32'd0);
        check_eq("t5_init_credits", 32'(credits_out), 32'd4);

        // 6: reset one cycle after a pop drops the in-flight word.
        clear_logs();
        push0(6'h3F);
        tick();
        check_eq("t6_popped", 32'(pop_log[0]), 32'd1);
        reset = 1'b1;
        tick();
        check_eq("t6_wr",      32'(bus.wr_enable), 32'd0);
        check_eq("t6_credits", 32'(credits_out),   32'd0);
        check_eq("t6_idle",    32'(idle_out),      32'd0);
        check_eq("t6_active",  32'(active_out),    32'd0);
        ticks(2);
        check_eq("t6_no_write", 32'(count_writes()), 32'd0);
        reset = 1'b0;
        clear_logs();
        push0(6'h15);
        ticks(4);
        check_eq("t6_stay_reset_pops", 32'(count_pops()), 32'd0);
        check_eq("t6_stay_reset_wr",   32'(count_writes()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
